alu_op_dispatcher: RTL and testbench
====================================

ALU_OP_DISPATCHER -- requirements
Module: alu_op_dispatcher

Interface
REQ-001 Parameter FUN_W, default 2: width of the function-select code.
REQ-002 Parameter NUM_UNITS, default 4: number of functional units, legal range 2..2**FUN_W.
REQ-003 Parameter TIMEOUT_CYC, default 255: maximum wait for unit completion, range 1..65535.
REQ-004 Parameter CNT_W, default 16: width of the completed-operation counter.
REQ-005 CLK  input  1  single clock; all state updates on rising edge.
REQ-006 RST  input  1  synchronous, active-high reset.
REQ-007 OP_VALID  input  1  operation request present.
REQ-008 ALU_FUN  input  FUN_W  target unit index.
REQ-009 OP_READY  output  1  dispatcher can accept a request.
REQ-010 UNIT_EN  output  NUM_UNITS  one-hot unit start pulse.
REQ-011 UNIT_DONE  input  NUM_UNITS  per-unit completion strobe.
REQ-012 UNIT_BUSY  output  NUM_UNITS  one-hot marker of the unit in flight.
REQ-013 OUT_VALID  output  1  one-cycle completion pulse.
REQ-014 ILLEGAL  output  1  one-cycle pulse, rejected code.
REQ-015 TIMEOUT_ERR  output  1  one-cycle pulse, unit abandoned.
REQ-016 OP_CNT  output  CNT_W  count of completed operations.

Function
REQ-017 FSM SHALL have states IDLE, ISSUE, WAIT; OP_READY SHALL be 1 only in IDLE.
REQ-018 Accept = OP_VALID & OP_READY at a rising edge; ALU_FUN SHALL be latched into an internal select register on accept.
REQ-019 Legal accept (ALU_FUN < NUM_UNITS): IDLE->ISSUE; UNIT_EN[sel] SHALL be 1 for exactly the ISSUE cycle; all other bits 0.
REQ-020 Illegal accept (ALU_FUN >= NUM_UNITS): FSM SHALL stay IDLE, ILLEGAL SHALL pulse 1 cycle after the edge, no UNIT_EN, OP_CNT unchanged.
REQ-021 UNIT_BUSY[sel] SHALL be 1 in ISSUE and WAIT, all bits 0 in IDLE.
REQ-022 UNIT_DONE[sel] SHALL be sampled in ISSUE and WAIT; UNIT_DONE bits of non-selected units and any UNIT_DONE in IDLE SHALL be ignored.
REQ-023 UNIT_DONE[sel] in ISSUE (zero-latency unit) SHALL go directly to IDLE; otherwise ISSUE->WAIT unconditionally.
REQ-024 On the edge sampling UNIT_DONE[sel]: FSM->IDLE, OUT_VALID SHALL pulse the following cycle (concurrent with OP_READY=1), OP_CNT SHALL increment.
REQ-025 OP_CNT SHALL wrap from 2**CNT_W-1 to 0 without flag.
REQ-026 Minimum issue-to-issue spacing SHALL be 2 cycles (accept, ISSUE with done, accept again).
REQ-027 OUT_VALID, ILLEGAL and TIMEOUT_ERR SHALL be mutually exclusive in any cycle.

Reset
REQ-028 RST sampled high SHALL force IDLE, select=0, timeout counter=0, OP_CNT=0, UNIT_EN=0, UNIT_BUSY=0, OUT_VALID=0, ILLEGAL=0, TIMEOUT_ERR=0; OP_READY=1 in the first cycle after reset.
REQ-029 RST in ISSUE or WAIT SHALL abort the operation without OUT_VALID or TIMEOUT_ERR; RST SHALL take priority over every input.

Configuration
REQ-030 Macro ALU_DISP_TIMEOUT_EN defined: a counter SHALL clear on entry to WAIT, increment each WAIT cycle; on reaching TIMEOUT_CYC without UNIT_DONE[sel], FSM->IDLE, TIMEOUT_ERR pulses 1 cycle, OP_CNT unchanged; UNIT_DONE[sel] on the same edge as expiry SHALL win (normal completion).
REQ-031 Macro undefined: WAIT SHALL persist until UNIT_DONE[sel] or RST; TIMEOUT_ERR port SHALL remain present, tied 0; no counter logic.

Verification
REQ-032 Reset, then OP_VALID=1, ALU_FUN=2, UNIT_DONE[2] 3 cycles after UNIT_EN -> UNIT_EN=4'b0100 one cycle, UNIT_BUSY=4'b0100 through done, OUT_VALID one pulse, OP_CNT=1.
REQ-033 NUM_UNITS=3, ALU_FUN=3 accepted -> ILLEGAL pulse, UNIT_EN=0, OP_READY stays 1, OP_CNT=0.
REQ-034 ALU_FUN=1 with UNIT_DONE[1] tied high and OP_VALID held, 4 ops -> accepts every 2 cycles, 4 OUT_VALID pulses, OP_CNT=4; UNIT_DONE[0] asserted throughout ignored.
REQ-035 ALU_DISP_TIMEOUT_EN, TIMEOUT_CYC=5, no done -> TIMEOUT_ERR pulse after 5 WAIT cycles, no OUT_VALID, OP_CNT unchanged; done exactly at expiry -> OUT_VALID, no TIMEOUT_ERR.
REQ-036 RST asserted in WAIT -> next cycle all outputs at reset values, no OUT_VALID; CNT_W=4 with 17 completions -> OP_CNT=1.

Source files
------------

// File: rtl/alu_op_dispatcher.sv
// Dispatches one operation at a time to NUM_UNITS functional units and tracks completion.
// Optional unit-completion watchdog enabled by defining ALU_DISP_TIMEOUT_EN.
module alu_op_dispatcher #(
  parameter int FUN_W       = 2,
  parameter int NUM_UNITS   = 4,
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 OP_VALID,
  input  logic [FUN_W-1:0]     ALU_FUN,
  output logic                 OP_READY,
  output logic [NUM_UNITS-1:0] UNIT_EN,
  input  logic [NUM_UNITS-1:0] UNIT_DONE,
  output logic [NUM_UNITS-1:0] UNIT_BUSY,
  output logic                 OUT_VALID,
  output logic                 ILLEGAL,
  output logic                 TIMEOUT_ERR,
  output logic [CNT_W-1:0]     OP_CNT
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  if (NUM_UNITS < 2 || NUM_UNITS > 2**FUN_W || TIMEOUT_CYC < 1 ||
      TIMEOUT_CYC > 65535 || CNT_W < 1) begin : g_param_check
    $error("alu_op_dispatcher: parameter out of range");
  end

  state_t               r_state, w_state_next;
  logic [FUN_W-1:0]     r_sel, w_sel_next;
  logic [CNT_W-1:0]     r_op_cnt, w_op_cnt_next;
  logic                 r_out_valid, w_out_valid_next;
  logic                 r_illegal, w_illegal_next;
  logic [NUM_UNITS-1:0] w_sel_onehot;
  logic                 w_accept;
  logic                 w_legal;
  logic                 w_done;

  // Decoding through a compare per unit keeps an out-of-range select harmless (all zeros).
  for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_sel_dec
    assign w_sel_onehot[gi] = (r_sel == FUN_W'(gi));
  end

  assign w_accept = OP_VALID && (r_state == IDLE);
  assign w_legal  = ({1'b0, ALU_FUN} < (FUN_W+1)'(NUM_UNITS));
  assign w_done   = |(UNIT_DONE & w_sel_onehot);

`ifdef ALU_DISP_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);
  logic [15:0] r_tmo, w_tmo_next;
  logic        r_timeout_err, w_timeout_err_next;
`endif

  always_comb begin
    w_state_next     = r_state;
    w_sel_next       = r_sel;
    w_op_cnt_next    = r_op_cnt;
    w_out_valid_next = 1'b0;
    w_illegal_next   = 1'b0;
`ifdef ALU_DISP_TIMEOUT_EN
    w_tmo_next         = r_tmo;
    w_timeout_err_next = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_sel_next = ALU_FUN;
          if (w_legal) begin
            w_state_next = ISSUE;
          end else begin
            w_illegal_next = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (w_done) begin
          w_state_next     = IDLE;
          w_out_valid_next = 1'b1;
          w_op_cnt_next    = r_op_cnt + 1'b1;
        end else begin
          w_state_next = WAIT;
`ifdef ALU_DISP_TIMEOUT_EN
          w_tmo_next   = '0;
`endif
        end
      end
      WAIT: begin
        // A completion on the expiry edge still counts as a normal completion.
        if (w_done) begin
          w_state_next     = IDLE;
          w_out_valid_next = 1'b1;
          w_op_cnt_next    = r_op_cnt + 1'b1;
        end
`ifdef ALU_DISP_TIMEOUT_EN
        else if (r_tmo == TMO_LAST) begin
          w_state_next       = IDLE;
          w_timeout_err_next = 1'b1;
        end else begin
          w_tmo_next = r_tmo + 16'd1;
        end
`endif
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= IDLE;
      r_sel       <= '0;
      r_op_cnt    <= '0;
      r_out_valid <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_sel       <= w_sel_next;
      r_op_cnt    <= w_op_cnt_next;
      r_out_valid <= w_out_valid_next;
      r_illegal   <= w_illegal_next;
    end
  end

`ifdef ALU_DISP_TIMEOUT_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_tmo         <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_tmo         <= w_tmo_next;
      r_timeout_err <= w_timeout_err_next;
    end
  end

  assign TIMEOUT_ERR = r_timeout_err;
`else
  assign TIMEOUT_ERR = 1'b0;
`endif

  assign OP_READY  = (r_state == IDLE);
  assign UNIT_EN   = (r_state == ISSUE) ? w_sel_onehot : '0;
  assign UNIT_BUSY = (r_state != IDLE) ? w_sel_onehot : '0;
  assign OUT_VALID = r_out_valid;
  assign ILLEGAL   = r_illegal;
  assign OP_CNT    = r_op_cnt;

endmodule

// File: tb/tb_alu_op_dispatcher.sv
// Directed testbench for alu_op_dispatcher: a 4-unit instance (5-cycle timeout, 4-bit counter)
// and a 3-unit instance share the stimulus; each scenario checks the instance it targets.
module tb_alu_op_dispatcher;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       OP_VALID = 1'b0;
  logic [1:0] ALU_FUN = 2'd0;
  logic [3:0] UNIT_DONE = 4'd0;

  logic       ready, ov, ill, terr;
  logic [3:0] en, busy, cnt;
  logic       ready3, ov3, ill3, terr3;
  logic [2:0] en3, busy3;
  logic [3:0] cnt3;

  int n_chk = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  alu_op_dispatcher #(.FUN_W(2), .NUM_UNITS(4), .TIMEOUT_CYC(5), .CNT_W(4)) u_dut (
    .CLK(CLK), .RST(RST), .OP_VALID(OP_VALID), .ALU_FUN(ALU_FUN), .OP_READY(ready),
    .UNIT_EN(en), .UNIT_DONE(UNIT_DONE), .UNIT_BUSY(busy), .OUT_VALID(ov),
    .ILLEGAL(ill), .TIMEOUT_ERR(terr), .OP_CNT(cnt)
  );

  alu_op_dispatcher #(.FUN_W(2), .NUM_UNITS(3), .TIMEOUT_CYC(5), .CNT_W(4)) u_dut3 (
    .CLK(CLK), .RST(RST), .OP_VALID(OP_VALID), .ALU_FUN(ALU_FUN), .OP_READY(ready3),
    .UNIT_EN(en3), .UNIT_DONE(UNIT_DONE[2:0]), .UNIT_BUSY(busy3), .OUT_VALID(ov3),
    .ILLEGAL(ill3), .TIMEOUT_ERR(terr3), .OP_CNT(cnt3)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    OP_VALID  = 1'b0;
    UNIT_DONE = 4'd0;
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", ready); end
    n_chk++; if (en !== 4'b0000) begin n_fail++; $display("FAIL reset_en: got %b expected 0000", en); end
    n_chk++; if (busy !== 4'b0000) begin n_fail++; $display("FAIL reset_busy: got %b expected 0000", busy); end
    n_chk++; if ({ov, ill, terr} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses: got %b expected 000", {ov, ill, terr}); end
    n_chk++; if (cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", cnt); end
    n_chk++; if (ready3 !== 1'b1 || cnt3 !== 4'd0) begin n_fail++; $display("FAIL reset_dut3: got ready=%b cnt=%0d expected ready=1 cnt=0", ready3, cnt3); end
    $display("test_reset done");
  endtask

  task automatic test_single_op();
    do_reset();
    OP_VALID = 1'b1;
    ALU_FUN  = 2'd2;
    tick();
    OP_VALID = 1'b0;
    n_chk++; if (en !== 4'b0100) begin n_fail++; $display("FAIL single_issue_en: got %b expected 0100", en); end
    n_chk++; if (busy !== 4'b0100 || ready !== 1'b0) begin n_fail++; $display("FAIL single_issue_busy: got busy=%b ready=%b expected busy=0100 ready=0", busy, ready); end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_chk++; if (en !== 4'b0000 || busy !== 4'b0100) begin n_fail++; $display("FAIL single_wait%0d: got en=%b busy=%b expected en=0000 busy=0100", i, en, busy); end
    end
    tick();
    UNIT_DONE = 4'b0100;
    n_chk++; if (busy !== 4'b0100 || ov !== 1'b0) begin n_fail++; $display("FAIL single_done_cycle: got busy=%b ov=%b expected busy=0100 ov=0", busy, ov); end
    tick();
    UNIT_DONE = 4'b0000;
    n_chk++; if (ov !== 1'b1 || ready !== 1'b1 || busy !== 4'b0000) begin n_fail++; $display("FAIL single_complete: got ov=%b ready=%b busy=%b expected 1 1 0000", ov, ready, busy); end
    n_chk++; if (cnt !== 4'd1) begin n_fail++; $display("FAIL single_cnt: got %0d expected 1", cnt); end
    tick();
    n_chk++; if (ov !== 1'b0 || cnt !== 4'd1) begin n_fail++; $display("FAIL single_after: got ov=%b cnt=%0d expected ov=0 cnt=1", ov, cnt); end
    $display("test_single_op: unit 2 completed, op_cnt=%0d", cnt);
  endtask

  task automatic test_illegal();
    do_reset();
    OP_VALID = 1'b1;
    ALU_FUN  = 2'd3;
    tick();
    OP_VALID = 1'b0;
    n_chk++; if (ill3 !== 1'b1) begin n_fail++; $display("FAIL illegal_pulse: got %b expected 1", ill3); end
    n_chk++; if (en3 !== 3'b000 || busy3 !== 3'b000) begin n_fail++; $display("FAIL illegal_en: got en=%b busy=%b expected 000 000", en3, busy3); end
    n_chk++; if (ready3 !== 1'b1 || cnt3 !== 4'd0 || ov3 !== 1'b0) begin n_fail++; $display("FAIL illegal_state: got ready=%b cnt=%0d ov=%b expected 1 0 0", ready3, cnt3, ov3); end
    n_chk++; if (ill !== 1'b0 || en !== 4'b1000) begin n_fail++; $display("FAIL illegal_legal_on_4: got ill=%b en=%b expected 0 1000", ill, en); end
    tick();
    n_chk++; if (ill3 !== 1'b0 || ready3 !== 1'b1) begin n_fail++; $display("FAIL illegal_one_cycle: got ill=%b ready=%b expected 0 1", ill3, ready3); end
    $display("test_illegal: code 3 rejected by 3-unit dispatcher");
  endtask

  task automatic test_back_to_back();
    do_reset();
    UNIT_DONE = 4'b0011;
    OP_VALID  = 1'b1;
    ALU_FUN   = 2'd1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_chk++; if (en !== 4'b0010 || ov !== 1'b0) begin n_fail++; $display("FAIL b2b_issue%0d: got en=%b ov=%b expected 0010 0", i, en, ov); end
      tick();
      n_chk++; if (ov !== 1'b1 || ready !== 1'b1 || cnt !== 4'(i + 1)) begin n_fail++; $display("FAIL b2b_done%0d: got ov=%b ready=%b cnt=%0d expected 1 1 %0d", i, ov, ready, cnt, i + 1); end
      $display("back_to_back op %0d completed, op_cnt=%0d", i, cnt);
    end
    OP_VALID = 1'b0;
    tick();
    n_chk++; if (ov !== 1'b0 || cnt !== 4'd4 || en !== 4'b0000) begin n_fail++; $display("FAIL b2b_end: got ov=%b cnt=%0d en=%b expected 0 4 0000", ov, cnt, en); end
    UNIT_DONE = 4'b0000;
  endtask

  task automatic test_timeout();
    do_reset();
    OP_VALID = 1'b1;
    ALU_FUN  = 2'd0;
    tick();
    OP_VALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_chk++; if (busy !== 4'b0001 || terr !== 1'b0) begin n_fail++; $display("FAIL tmo_wait%0d: got busy=%b terr=%b expected 0001 0", i, busy, terr); end
    end
    tick();
`ifdef ALU_DISP_TIMEOUT_EN
    n_chk++; if (terr !== 1'b1 || ov !== 1'b0 || ready !== 1'b1) begin n_fail++; $display("FAIL tmo_expire: got terr=%b ov=%b ready=%b expected 1 0 1", terr, ov, ready); end
    n_chk++; if (cnt !== 4'd0 || busy !== 4'b0000) begin n_fail++; $display("FAIL tmo_state: got cnt=%0d busy=%b expected 0 0000", cnt, busy); end
    tick();
    n_chk++; if (terr !== 1'b0) begin n_fail++; $display("FAIL tmo_one_cycle: got %b expected 0", terr); end
`else
    n_chk++; if (terr !== 1'b0 || busy !== 4'b0001 || ready !== 1'b0) begin n_fail++; $display("FAIL tmo_disabled: got terr=%b busy=%b ready=%b expected 0 0001 0", terr, busy, ready); end
`endif
    $display("test_timeout: no-done case finished, timeout_err=%b", terr);
    do_reset();
    OP_VALID = 1'b1;
    tick();
    OP_VALID = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    UNIT_DONE = 4'b0001;
    tick();
    UNIT_DONE = 4'b0000;
    n_chk++; if (ov !== 1'b1 || terr !== 1'b0 || cnt !== 4'd1) begin n_fail++; $display("FAIL tmo_done_at_expiry: got ov=%b terr=%b cnt=%0d expected 1 0 1", ov, terr, cnt); end
    $display("test_timeout: done-at-expiry completed, op_cnt=%0d", cnt);
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    OP_VALID  = 1'b1;
    ALU_FUN   = 2'd2;
    UNIT_DONE = 4'b0100;
    tick();
    OP_VALID = 1'b0;
    tick();
    n_chk++; if (cnt !== 4'd1) begin n_fail++; $display("FAIL rst_pre_cnt: got %0d expected 1", cnt); end
    UNIT_DONE = 4'b0000;
    OP_VALID  = 1'b1;
    tick();
    OP_VALID = 1'b0;
    tick();
    n_chk++; if (busy !== 4'b0100 || ready !== 1'b0) begin n_fail++; $display("FAIL rst_pre_wait: got busy=%b ready=%b expected 0100 0", busy, ready); end
    RST       = 1'b1;
    OP_VALID  = 1'b1;
    UNIT_DONE = 4'b0100;
    tick();
    RST       = 1'b0;
    OP_VALID  = 1'b0;
    UNIT_DONE = 4'b0000;
    n_chk++; if (ready !== 1'b1 || en !== 4'b0000 || busy !== 4'b0000) begin n_fail++; $display("FAIL rst_wait_state: got ready=%b en=%b busy=%b expected 1 0000 0000", ready, en, busy); end
    n_chk++; if ({ov, ill, terr} !== 3'b000 || cnt !== 4'd0) begin n_fail++; $display("FAIL rst_wait_outs: got pulses=%b cnt=%0d expected 000 0", {ov, ill, terr}, cnt); end
    tick();
    n_chk++; if (ov !== 1'b0 || terr !== 1'b0) begin n_fail++; $display("FAIL rst_wait_after: got ov=%b terr=%b expected 0 0", ov, terr); end
    $display("test_reset_in_wait: operation aborted");
  endtask

  task automatic test_wrap();
    do_reset();
    UNIT_DONE = 4'b0010;
    ALU_FUN   = 2'd1;
    OP_VALID  = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      tick();
      tick();
      if (i == 15) begin
        n_chk++; if (cnt !== 4'd15) begin n_fail++; $display("FAIL wrap_15: got %0d expected 15", cnt); end
      end
      if (i == 16) begin
        n_chk++; if (cnt !== 4'd0) begin n_fail++; $display("FAIL wrap_16: got %0d expected 0", cnt); end
      end
    end
    OP_VALID = 1'b0;
    UNIT_DONE = 4'b0000;
    tick();
    n_chk++; if (cnt !== 4'd1) begin n_fail++; $display("FAIL wrap_17: got %0d expected 1", cnt); end
    $display("test_wrap: 17 completions, op_cnt=%0d", cnt);
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_illegal();
    test_back_to_back();
    test_timeout();
    test_reset_in_wait();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
